// File: rtl/dispatch_unit.sv
// Dispatch stage: one-entry dispatch register between the IFQ and four issue queues, with ROB tag
// allocation and local J/JAL redirect. Define DISPATCH_BTFN_EN to also redirect backward BEQ/BNE.
module dispatch_unit #(
    parameter int ROB_DEPTH = 32,
    parameter int TAG_W     = 5,
    parameter int NUM_IQ    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ifq_pc_out,
    input  logic [31:0]       ifq_inst,
    input  logic              ifq_empty,
    output logic              ifq_rd_en,
    output logic [31:0]       ifq_jump_branch_address,
    output logic              ifq_jump_branch_valid,
    input  logic              rob_full,
    output logic              rob_alloc,
    output logic [TAG_W-1:0]  disp_tag,
    output logic [31:0]       disp_inst,
    output logic [31:0]       disp_pc,
    output logic [NUM_IQ-1:0] iq_valid,
    input  logic [NUM_IQ-1:0] iq_ready,
    input  logic              flush,
    input  logic [TAG_W-1:0]  flush_tag
);

    generate
        if (NUM_IQ != 4) begin : g_bad_num_iq
            $error("dispatch_unit: NUM_IQ must be 4");
        end
        if ((2 ** TAG_W) < ROB_DEPTH) begin : g_bad_tag_w
            $error("dispatch_unit: TAG_W too narrow for ROB_DEPTH");
        end
    endgenerate

    typedef enum logic [2:0] {CL_INT, CL_LDST, CL_MULT, CL_DIV, CL_NOQ} cls_t;
    typedef enum logic {S_RUN, S_REDIRECT} state_t;

    state_t           state;
    cls_t             d_class;
    cls_t             new_class;
    logic             d_valid;
    logic [TAG_W-1:0] tail;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             redirect_now;
    logic [31:0]      redirect_target;
    logic [3:0]       j_region;
    logic [1:0]       iq_sel;
    logic             needs_rob;
    logic             fire;
    logic             load;

    assign opcode   = ifq_inst[31:26];
    assign funct    = ifq_inst[5:0];
    assign j_region = 4'((ifq_pc_out + 32'd4) >> 28);

    always_comb begin
        new_class = CL_INT;
        if (opcode == 6'h23 || opcode == 6'h2B)
            new_class = CL_LDST;
        else if (opcode == 6'h00 && (funct == 6'h18 || funct == 6'h19))
            new_class = CL_MULT;
        else if (opcode == 6'h00 && (funct == 6'h1A || funct == 6'h1B))
            new_class = CL_DIV;
        else if (opcode == 6'h02)
            new_class = CL_NOQ;
    end

`ifdef DISPATCH_BTFN_EN
    logic        is_jump;
    logic        is_bwd_br;
    logic [31:0] br_target;

    assign is_jump   = (opcode == 6'h02) || (opcode == 6'h03);
    assign is_bwd_br = ((opcode == 6'h04) || (opcode == 6'h05)) && ifq_inst[15];
    assign br_target = ifq_pc_out + 32'd4 + {{14{ifq_inst[15]}}, ifq_inst[15:0], 2'b00};

    always_comb begin
        redirect_now    = is_jump || is_bwd_br;
        redirect_target = is_jump ? {j_region, ifq_inst[25:0], 2'b00} : br_target;
    end
`else
    always_comb begin
        redirect_now    = (opcode == 6'h02) || (opcode == 6'h03);
        redirect_target = {j_region, ifq_inst[25:0], 2'b00};
    end
`endif

    // Only ROB-consuming classes are stalled by rob_full; a J always drains.
    assign iq_sel    = d_class[1:0];
    assign needs_rob = (d_class != CL_NOQ);
    assign fire      = d_valid && (!needs_rob || (iq_ready[iq_sel] && !rob_full));
    assign load      = !ifq_empty && (!d_valid || fire) && (state == S_RUN) && !flush;
    assign ifq_rd_en = load;
    assign rob_alloc = fire && needs_rob && !flush;
    assign disp_tag  = tail;

    always_comb begin
        iq_valid = '0;
        for (int unsigned i = 0; i < NUM_IQ; i++)
            iq_valid[i] = d_valid && needs_rob && !rob_full && (iq_sel == 2'(i));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                   <= S_RUN;
            d_valid                 <= 1'b0;
            d_class                 <= CL_INT;
            tail                    <= '0;
            disp_inst               <= '0;
            disp_pc                 <= '0;
            ifq_jump_branch_valid   <= 1'b0;
            ifq_jump_branch_address <= '0;
        end else if (flush) begin
            state                 <= S_RUN;
            d_valid               <= 1'b0;
            tail                  <= flush_tag;
            ifq_jump_branch_valid <= 1'b0;
        end else begin
            if (rob_alloc)
                tail <= (tail == TAG_W'(ROB_DEPTH - 1)) ? '0 : tail + 1'b1;

            if (load) begin
                d_valid   <= 1'b1;
                d_class   <= new_class;
                disp_inst <= ifq_inst;
                disp_pc   <= ifq_pc_out;
            end else if (fire) begin
                d_valid <= 1'b0;
            end

            ifq_jump_branch_valid <= 1'b0;
            case (state)
                S_RUN: begin
                    if (load && redirect_now) begin
                        state                   <= S_REDIRECT;
                        ifq_jump_branch_valid   <= 1'b1;
                        ifq_jump_branch_address <= redirect_target;
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

endmodule
